// File: rtl/alu_result_checker.sv
// Scoreboard-style checker that predicts an ALU result from its operands and op code,
// lines the prediction up with the ALU's fixed latency, and tallies pass/fail with first-failure capture.
module alu_result_checker #(
  parameter int WORD_SIZE    = 32,
  parameter int ALU_CON_SIZE = 4,
  parameter int LATENCY      = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  input  logic [ALU_CON_SIZE-1:0]     alu_con,
  input  logic signed [WORD_SIZE-1:0] data_in_1,
  input  logic signed [WORD_SIZE-1:0] data_in_2,
  input  logic signed [WORD_SIZE-1:0] data_out,
  input  logic                        clear,
  output logic                        chk_valid,
  output logic                        mismatch,
  output logic [CNT_WIDTH-1:0]        pass_cnt,
  output logic [CNT_WIDTH-1:0]        fail_cnt,
  output logic                        err_flag,
  output logic [ALU_CON_SIZE-1:0]     ff_con,
  output logic [WORD_SIZE-1:0]        ff_exp,
  output logic [WORD_SIZE-1:0]        ff_got
);

  localparam int SH_W = $clog2(WORD_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [ALU_CON_SIZE-1:0] OP_ADD  = ALU_CON_SIZE'(0);
  localparam logic [ALU_CON_SIZE-1:0] OP_SUB  = ALU_CON_SIZE'(1);
  localparam logic [ALU_CON_SIZE-1:0] OP_AND  = ALU_CON_SIZE'(2);
  localparam logic [ALU_CON_SIZE-1:0] OP_OR   = ALU_CON_SIZE'(3);
  localparam logic [ALU_CON_SIZE-1:0] OP_XOR  = ALU_CON_SIZE'(4);
  localparam logic [ALU_CON_SIZE-1:0] OP_NOR  = ALU_CON_SIZE'(5);
  localparam logic [ALU_CON_SIZE-1:0] OP_SLL  = ALU_CON_SIZE'(6);
  localparam logic [ALU_CON_SIZE-1:0] OP_SRL  = ALU_CON_SIZE'(7);
  localparam logic [ALU_CON_SIZE-1:0] OP_SRA  = ALU_CON_SIZE'(8);
  localparam logic [ALU_CON_SIZE-1:0] OP_SLT  = ALU_CON_SIZE'(9);
  localparam logic [ALU_CON_SIZE-1:0] OP_SLTU = ALU_CON_SIZE'(10);

  logic [SH_W-1:0]      sh_s;
  logic [WORD_SIZE-1:0] exp_s;
  logic                 checked_s;

  logic                    pipe_vld_r [LATENCY];
  logic [ALU_CON_SIZE-1:0] pipe_con_r [LATENCY];
  logic [WORD_SIZE-1:0]    pipe_exp_r [LATENCY];

  assign sh_s = data_in_2[SH_W-1:0];

  // Reference model of the ALU; op codes outside the table are not checked.
  always_comb begin
    exp_s     = '0;
    checked_s = 1'b1;
    case (alu_con)
      OP_ADD:  exp_s = data_in_1 + data_in_2;
      OP_SUB:  exp_s = data_in_1 - data_in_2;
      OP_AND:  exp_s = data_in_1 & data_in_2;
      OP_OR:   exp_s = data_in_1 | data_in_2;
      OP_XOR:  exp_s = data_in_1 ^ data_in_2;
      OP_NOR:  exp_s = ~(data_in_1 | data_in_2);
      OP_SLL:  exp_s = data_in_1 << sh_s;
      OP_SRL:  exp_s = $unsigned(data_in_1) >> sh_s;
      OP_SRA:  exp_s = data_in_1 >>> sh_s;
      OP_SLT:  exp_s = {{(WORD_SIZE-1){1'b0}}, (data_in_1 < data_in_2)};
      OP_SLTU: exp_s = {{(WORD_SIZE-1){1'b0}}, ($unsigned(data_in_1) < $unsigned(data_in_2))};
      default: begin
        exp_s     = '0;
        checked_s = 1'b0;
      end
    endcase
  end

  // Fixed-latency delay line; its tail lines up with data_out of the same operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_r[i] <= 1'b0;
        pipe_con_r[i] <= '0;
        pipe_exp_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= in_valid && checked_s;
      pipe_con_r[0] <= alu_con;
      pipe_exp_r[0] <= exp_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_con_r[i] <= pipe_con_r[i-1];
        pipe_exp_r[i] <= pipe_exp_r[i-1];
      end
    end
  end

  assign chk_valid = pipe_vld_r[LATENCY-1];
  assign mismatch  = chk_valid && (data_out != pipe_exp_r[LATENCY-1]);

  // Saturating tallies and first-failure capture; clear wins over a same-cycle compare.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      ff_con   <= '0;
      ff_exp   <= '0;
      ff_got   <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      ff_con   <= '0;
      ff_exp   <= '0;
      ff_got   <= '0;
    end else if (chk_valid) begin
      if (mismatch) begin
        if (fail_cnt != CNT_MAX) begin
          fail_cnt <= fail_cnt + CNT_ONE;
        end
        if (!err_flag) begin
          err_flag <= 1'b1;
          ff_con   <= pipe_con_r[LATENCY-1];
          ff_exp   <= pipe_exp_r[LATENCY-1];
          ff_got   <= data_out;
        end
      end else if (pass_cnt != CNT_MAX) begin
        pass_cnt <= pass_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a LATENCY=1/CNT_WIDTH=2 instance and a LATENCY=3 instance,
// each fed by a delayed ALU stand-in, with a queue of predicted compares checked every cycle.
module tb_alu_result_checker;

  typedef struct {
    int          due;
    logic        mm;
    logic [3:0]  con;
    logic [31:0] exp;
    logic [31:0] got;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: LATENCY=1, CNT_WIDTH=2
  logic        rstn_a = 1'b1, iv_a = 1'b0, clear_a = 1'b0;
  logic [3:0]  con_a = 4'd0;
  logic [31:0] a_a = 32'd0, b_a = 32'd0, plan_a = 32'd0, dl_a = 32'd0;
  logic        cv_a, mm_a, err_a;
  logic [1:0]  pass_a, fail_a;
  logic [3:0]  ffc_a;
  logic [31:0] ffe_a, ffg_a;

  // instance B: LATENCY=3, CNT_WIDTH=16
  logic        rstn_b = 1'b1, iv_b = 1'b0, clear_b = 1'b0;
  logic [3:0]  con_b = 4'd0;
  logic [31:0] a_b = 32'd0, b_b = 32'd0, plan_b = 32'd0;
  logic [31:0] dl_b0 = 32'd0, dl_b1 = 32'd0, dl_b2 = 32'd0;
  logic        cv_b, mm_b, err_b;
  logic [15:0] pass_b, fail_b;
  logic [3:0]  ffc_b;
  logic [31:0] ffe_b, ffg_b;

  alu_result_checker #(.WORD_SIZE(32), .ALU_CON_SIZE(4), .LATENCY(1), .CNT_WIDTH(2)) u_a (
    .clk(clk), .rstn(rstn_a), .in_valid(iv_a), .alu_con(con_a), .data_in_1(a_a), .data_in_2(b_a),
    .data_out(dl_a), .clear(clear_a), .chk_valid(cv_a), .mismatch(mm_a), .pass_cnt(pass_a),
    .fail_cnt(fail_a), .err_flag(err_a), .ff_con(ffc_a), .ff_exp(ffe_a), .ff_got(ffg_a));

  alu_result_checker #(.WORD_SIZE(32), .ALU_CON_SIZE(4), .LATENCY(3), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rstn(rstn_b), .in_valid(iv_b), .alu_con(con_b), .data_in_1(a_b), .data_in_2(b_b),
    .data_out(dl_b2), .clear(clear_b), .chk_valid(cv_b), .mismatch(mm_b), .pass_cnt(pass_b),
    .fail_cnt(fail_b), .err_flag(err_b), .ff_con(ffc_b), .ff_exp(ffe_b), .ff_got(ffg_b));

  // ALU stand-in: the planned result emerges LATENCY edges after the operands are sampled
  always @(posedge clk) begin
    dl_a  <= plan_a;
    dl_b0 <= plan_b;
    dl_b1 <= dl_b0;
    dl_b2 <= dl_b1;
  end

  sb_t  sbq [2][$];
  int   lat [2]  = '{1, 3};
  int   smax [2] = '{3, 65535};
  int   m_pass [2], m_fail [2];
  logic m_err [2];
  logic [3:0]  m_con [2];
  logic [31:0] m_exp [2], m_got [2];
  int   n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_exp(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b);
    case (con)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return 32'($signed(a) >>> b[4:0]);
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic zero_model(input int d);
    m_pass[d] = 0; m_fail[d] = 0; m_err[d] = 1'b0;
    m_con[d] = 4'd0; m_exp[d] = 32'd0; m_got[d] = 32'd0;
  endtask

  task automatic mon(input int d, input logic cv, input logic mm);
    sb_t   e;
    string nm;
    nm = (d == 0) ? "L1" : "L3";
    if (sbq[d].size() != 0 && sbq[d][0].due == cyc) begin
      e = sbq[d].pop_front();
      chk({nm, " chk_valid"}, 64'(cv), 64'(1'b1));
      chk({nm, " mismatch"}, 64'(mm), 64'(e.mm));
      if (e.mm) begin
        if (m_fail[d] < smax[d]) m_fail[d]++;
        if (!m_err[d]) begin
          m_err[d] = 1'b1; m_con[d] = e.con; m_exp[d] = e.exp; m_got[d] = e.got;
        end
      end else if (m_pass[d] < smax[d]) begin
        m_pass[d]++;
      end
    end else begin
      chk({nm, " idle chk_valid"}, 64'(cv), 64'(1'b0));
      chk({nm, " idle mismatch"}, 64'(mm), 64'(1'b0));
    end
  endtask

  // scoreboard side: every cycle either the predicted compare or silence
  always @(negedge clk) begin
    mon(0, cv_a, mm_a);
    mon(1, cv_b, mm_b);
  end

  task automatic check_state(input int d);
    if (d == 0) begin
      chk("L1 pass_cnt", 64'(pass_a), 64'(m_pass[0]));
      chk("L1 fail_cnt", 64'(fail_a), 64'(m_fail[0]));
      chk("L1 err_flag", 64'(err_a), 64'(m_err[0]));
      chk("L1 ff_con", 64'(ffc_a), 64'(m_con[0]));
      chk("L1 ff_exp", 64'(ffe_a), 64'(m_exp[0]));
      chk("L1 ff_got", 64'(ffg_a), 64'(m_got[0]));
    end else begin
      chk("L3 pass_cnt", 64'(pass_b), 64'(m_pass[1]));
      chk("L3 fail_cnt", 64'(fail_b), 64'(m_fail[1]));
      chk("L3 err_flag", 64'(err_b), 64'(m_err[1]));
      chk("L3 ff_con", 64'(ffc_b), 64'(m_con[1]));
      chk("L3 ff_exp", 64'(ffe_b), 64'(m_exp[1]));
      chk("L3 ff_got", 64'(ffg_b), 64'(m_got[1]));
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [3:0] con,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] dout);
    sb_t         e;
    logic [31:0] x;
    @(negedge clk); #1;
    x = alu_exp(con, a, b);
    if (d == 0) begin
      iv_a = v; con_a = con; a_a = a; b_a = b; plan_a = dout;
    end else begin
      iv_b = v; con_b = con; a_b = a; b_b = b; plan_b = dout;
    end
    if (v && con <= 4'd10) begin
      e.due = cyc + lat[d]; e.mm = (dout !== x); e.con = con; e.exp = x; e.got = dout;
      sbq[d].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      iv_a = 1'b0;
      iv_b = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rx;
    zero_model(0);
    zero_model(1);
    #1 rstn_a = 1'b0; rstn_b = 1'b0;
    #2;
    chk("reset chk_valid", 64'(cv_a), 64'(1'b0));
    chk("reset mismatch", 64'(mm_a), 64'(1'b0));
    check_state(0);
    check_state(1);
    @(negedge clk); #1 rstn_a = 1'b1; rstn_b = 1'b1;

    drive(0, 1'b1, 4'd0, 32'd7, 32'd5, 32'd12);
    idle(2);
    chk("add pass_cnt", 64'(pass_a), 64'd1);

    drive(0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    drive(0, 1'b1, 4'd8, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    drive(0, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1);
    drive(0, 1'b1, 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0);
    drive(0, 1'b1, 4'd6, 32'd1, 32'd31, 32'h8000_0000);
    drive(0, 1'b1, 4'd7, 32'h8000_0000, 32'd31, 32'd1);
    drive(0, 1'b1, 4'd5, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
    idle(2);
    chk("saturated pass_cnt", 64'(pass_a), 64'd3);
    check_state(0);

    for (int i = 0; i <= 10; i++) begin
      ra = $urandom; rb = $urandom;
      drive(0, 1'b1, 4'(i), ra, rb, alu_exp(4'(i), ra, rb));
    end
    drive(0, 1'b1, 4'd12, 32'd1, 32'd2, 32'hDEAD_BEEF);
    drive(0, 1'b0, 4'd0, 32'd1, 32'd2, 32'hDEAD_BEEF);
    idle(2);
    check_state(0);

    drive(0, 1'b1, 4'd1, 32'd3, 32'd5, 32'd0);
    drive(0, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F, 32'd0);
    idle(2);
    chk("first-fail fail_cnt", 64'(fail_a), 64'd2);
    chk("first-fail err_flag", 64'(err_a), 64'd1);
    chk("first-fail ff_con", 64'(ffc_a), 64'd1);
    chk("first-fail ff_exp", 64'(ffe_a), 64'hFFFF_FFFE);
    chk("first-fail ff_got", 64'(ffg_a), 64'd0);

    drive(0, 1'b1, 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd1);
    drive(0, 1'b1, 4'd3, 32'd1, 32'd2, 32'd7);
    idle(2);
    chk("saturated fail_cnt", 64'(fail_a), 64'd3);
    check_state(0);

    drive(0, 1'b1, 4'd3, 32'd1, 32'd2, 32'd5);
    @(negedge clk); #1;
    clear_a = 1'b1; iv_a = 1'b0;
    @(posedge clk); #1;
    clear_a = 1'b0;
    zero_model(0);
    idle(1);
    chk("clear pass_cnt", 64'(pass_a), 64'd0);
    chk("clear fail_cnt", 64'(fail_a), 64'd0);
    chk("clear err_flag", 64'(err_a), 64'd0);
    check_state(0);

    drive(0, 1'b1, 4'd0, 32'd1, 32'd1, 32'd2);
    @(negedge clk); #1;
    rstn_a = 1'b0; iv_a = 1'b0;
    #1;
    chk("async reset chk_valid", 64'(cv_a), 64'(1'b0));
    chk("async reset mismatch", 64'(mm_a), 64'(1'b0));
    sbq[0].delete();
    zero_model(0);
    check_state(0);
    @(negedge clk); #1 rstn_a = 1'b1;

    drive(1, 1'b1, 4'd0, 32'd10, 32'd20, 32'd30);
    drive(1, 1'b1, 4'd1, 32'd10, 32'd20, 32'hFFFF_FFF6);
    @(negedge clk); #1;
    iv_b = 1'b1; con_b = 4'd4; a_b = 32'd3; b_b = 32'd6; plan_b = 32'd5;
    rstn_b = 1'b0;
    sbq[1].delete();
    zero_model(1);
    @(negedge clk); #1;
    rstn_b = 1'b1; iv_b = 1'b0;
    idle(4);
    check_state(1);

    drive(1, 1'b1, 4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977);
    idle(5);
    chk("L3 fresh pass_cnt", 64'(pass_b), 64'd1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      rx = alu_exp(4'(i), ra, rb);
      drive(1, 1'b1, 4'(i), ra, rb, (i % 3 == 1) ? ~rx : rx);
    end
    idle(6);
    check_state(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
